uart_word_tx_sched: RTL
=======================

// Module: uart_word_tx_sched
// PURPOSE
//  Round-robin scheduler feeding 16-bit words from two sources to one byte-wide UART transmitter.
//  - Grants one source per word and latches its word.
//  - Sends the word as two bytes using a tx_start/tx_busy handshake, so no byte is sent while the TX is busy.
//  - Sits between word producers and the UART TX core. Replaces free-running word-to-byte splitting where TX backpressure matters.
// PARAMETERS
//  MSB_FIRST     0   0: low byte first, then high byte; 1: high byte first
//  GAP_CYCLES    0   idle ce-cycles between the two bytes of a word (0..255)
//  ACK_TIMEOUT   16  ce-cycles to wait for tx_busy to rise after tx_start (>=2)
// PORTS
//  clk         in   1   system clock, rising edge
//  rst_n       in   1   reset, asynchronous, active-low
//  ce          in   1   clock enable; 0 freezes all state
//  req0_dv     in   1   source 0 word valid (level, held until req0_ack)
//  req0_word   in   16  source 0 word
//  req0_ack    out  1   1-clk pulse: source 0 word accepted
//  req1_dv     in   1   source 1 word valid (level, held until req1_ack)
//  req1_word   in   16  source 1 word
//  req1_ack    out  1   1-clk pulse: source 1 word accepted
//  tx_busy     in   1   UART TX busy
//  tx_start    out  1   1-clk pulse: tx_byte is valid, start transmission
//  tx_byte     out  8   byte to transmit; held stable until the next tx_start
//  grant_id    out  1   source of the word in flight (last granted when idle)
//  busy        out  1   1 whenever the FSM is not in IDLE
//  tx_err      out  1   1-clk pulse: ACK_TIMEOUT expired, word aborted
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE.
//  - All outputs 0 and last_grant=1 (source 0 wins first).
//  - In-flight word discarded; no ack is issued for it.
//  ce=0: all registers hold.
//  - Pulse outputs (ack, tx_start, tx_err) still clear on the next clk edge, so each pulse lasts exactly one clk.
//  FSM states: IDLE, START, WAIT_RISE, WAIT_FALL, GAP. A phase bit ph selects the byte: 0 = first, 1 = second.
//  IDLE: if any reqN_dv=1, grant one source.
//  - Only one valid: grant it. Both valid: grant the source != last_grant.
//  - Latch word; set grant_id and last_grant; pulse reqN_ack on the next cycle; ph<=0; go to START.
//  START: wait while tx_busy=1. Once tx_busy=0:
//  - Drive tx_byte = word[7:0] or word[15:8] per MSB_FIRST^ph.
//  - Pulse tx_start; clear timeout counter; go to WAIT_RISE.
//  WAIT_RISE: tx_busy=1 -> WAIT_FALL.
//  - Otherwise count ce-cycles. When the count reaches ACK_TIMEOUT: pulse tx_err, go to IDLE, do not send the remaining byte.
//  WAIT_FALL: on tx_busy=0:
//  - ph=0 -> ph<=1; go to GAP (or directly to START if GAP_CYCLES=0).
//  - ph=1 -> IDLE.
//  GAP: count GAP_CYCLES ce-cycles -> START.
//  Latency, idle TX: dv sampled at edge E0 -> ack high E0..E1 -> tx_start high E1..E2.
//  Back-to-back: from IDLE after the second byte, a new grant may occur in the same cycle.
//  - At most one word in flight.
//  - A dv still high during the ack cycle is not treated as a new request: arbitration happens only in IDLE.
//  Simultaneous requests: grants strictly alternate while both stay valid.
//  A source dropping dv before its ack loses its slot. No partial word is ever sent.
// TESTING
//  1 req0 word 0xA55A, TX model raises busy 1 cycle after start for 10 cycles
//    -> tx_byte 0x5A then 0xA5; one req0_ack; grant_id=0; busy falls after the 2nd busy fall.
//  2 req0=0x1234 and req1=0xABCD both valid from reset, re-asserted after ack
//    -> byte stream 34 12 CD AB 34 12 CD AB; acks alternate 0,1,0,1.
//  3 MSB_FIRST=1, GAP_CYCLES=3, word 0xBEEF
//    -> 0xBE then 0xEF; exactly 3 ce-cycles between busy fall and 2nd tx_start.
//  4 tx_busy held 0 after first tx_start, ACK_TIMEOUT=16
//    -> tx_err pulse 16 cycles later; FSM in IDLE; no second tx_start.
//  5 ce=0 for 5 cycles during WAIT_FALL while tx_busy drops
//    -> no state change until ce=1; no duplicate tx_start; correct 2nd byte.
//  6 rst_n=0 during 2nd-byte WAIT_FALL
//    -> all outputs 0 immediately; after release, word 0x00FF sends 0xFF first; req0 granted first.

Source files
------------

// File: rtl/uart_word_tx_sched.sv
// uart_word_tx_sched: round-robin arbiter of two 16-bit word sources onto a byte-wide UART TX.
// Each granted word goes out as two bytes, paced by the tx_start/tx_busy handshake.
module uart_word_tx_sched #(
   parameter bit MSB_FIRST   = 1'b0,
   parameter int GAP_CYCLES  = 0,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   input  logic        req0_dv,
   input  logic [15:0] req0_word,
   output logic        req0_ack,
   input  logic        req1_dv,
   input  logic [15:0] req1_word,
   output logic        req1_ack,
   input  logic        tx_busy,
   output logic        tx_start,
   output logic [7:0]  tx_byte,
   output logic        grant_id,
   output logic        busy,
   output logic        tx_err
);
   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, START, WAIT_RISE, WAIT_FALL, GAP} state_t;
   state_t        state;
   logic          ph;
   logic          last_grant;
   logic [15:0]   word;
   logic [TW-1:0] to_cnt;
   logic [7:0]    gap_cnt;
   logic          gnt;
   // with both sources pending, the one not served last wins
   assign gnt = (req0_dv && req1_dv) ? ~last_grant : req1_dv;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ph         <= 1'b0;
         last_grant <= 1'b1;
         word       <= '0;
         to_cnt     <= '0;
         gap_cnt    <= '0;
         req0_ack   <= 1'b0;
         req1_ack   <= 1'b0;
         tx_start   <= 1'b0;
         tx_byte    <= '0;
         grant_id   <= 1'b0;
         busy       <= 1'b0;
         tx_err     <= 1'b0;
      end else begin
         req0_ack <= 1'b0;
         req1_ack <= 1'b0;
         tx_start <= 1'b0;
         tx_err   <= 1'b0;
         if (ce) begin
            case (state)
               IDLE: if (req0_dv || req1_dv) begin
                  grant_id   <= gnt;
                  last_grant <= gnt;
                  word       <= gnt ? req1_word : req0_word;
                  req0_ack   <= ~gnt;
                  req1_ack   <= gnt;
                  ph         <= 1'b0;
                  busy       <= 1'b1;
                  state      <= START;
               end
               START: if (!tx_busy) begin
                  tx_byte  <= (ph ^ MSB_FIRST) ? word[15:8] : word[7:0];
                  tx_start <= 1'b1;
                  to_cnt   <= '0;
                  state    <= WAIT_RISE;
               end
               WAIT_RISE: if (tx_busy) state <= WAIT_FALL;
                  else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                     tx_err <= 1'b1;
                     busy   <= 1'b0;
                     state  <= IDLE;
                  end else to_cnt <= to_cnt + 1'b1;
               WAIT_FALL: if (!tx_busy) begin
                  if (ph) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     ph      <= 1'b1;
                     gap_cnt <= '0;
                     state   <= (GAP_CYCLES == 0) ? START : GAP;
                  end
               end
               GAP: if (gap_cnt == 8'(GAP_CYCLES - 1)) state <= START;
                  else gap_cnt <= gap_cnt + 1'b1;
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
